// File: rtl/approx_err_monitor.sv
// Accuracy monitor for the approximate adder family: counts erring samples,
// accumulates and tracks the maximum error distance, reports mean ED at end of run.
// Latency: accumulators update 2 cycles after accept; done rises 3 cycles after the last accept.
// Backpressure: in_ready high only while running; drops the cycle after the N-th accept.
// Optional APPROX_ERR_BIAS_EN adds the signed error accumulator bias_acc and mean_bias.
module approx_err_monitor #(
   parameter int WIDTH  = 16,
   parameter int LOG2_N = 10,
   parameter int ACC_W  = WIDTH + 1 + LOG2_N
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   input  logic [WIDTH:0]         s_approx,
   output logic                   busy,
   output logic                   done,
   output logic [LOG2_N:0]        err_count,
   output logic [ACC_W-1:0]       sum_ed,
   output logic [WIDTH:0]         max_ed,
   output logic [WIDTH:0]         mean_ed
`ifdef APPROX_ERR_BIAS_EN
   ,
   output logic signed [ACC_W:0]  bias_acc,
   output logic signed [WIDTH+1:0] mean_bias
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'((2**LOG2_N) - 1);

   state_t                state, state_nxt;
   logic [LOG2_N:0]       cnt;
   logic                  accept, clear, enter_done;
   logic                  s1_vld, s2_vld;
   logic [WIDTH:0]        s1_exact, s1_sapx;
   logic [WIDTH:0]        s2_ed;
   logic signed [WIDTH+1:0] diff;
   logic [WIDTH:0]        ed_c;
`ifdef APPROX_ERR_BIAS_EN
   logic signed [WIDTH+1:0] s2_diff;
`endif

   assign accept = in_valid & in_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      clear      = 1'b0;
      enter_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && cnt == LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!s1_vld && !s2_vld) begin
               enter_done = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accepted-sample counter; restarts with each run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
   end

   // Error distance from the stage-1 registers; the difference of two
   // WIDTH+1-bit unsigned values always has a magnitude that fits WIDTH+1 bits.
   always_comb begin
      diff = $signed({1'b0, s1_sapx}) - $signed({1'b0, s1_exact});
      ed_c = diff[WIDTH:0];
      if (diff[WIDTH+1]) ed_c = (WIDTH+1)'(-diff);
   end

   // Two pipeline stages: exact sum capture, then error distance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld   <= 1'b0;
         s2_vld   <= 1'b0;
         s1_exact <= '0;
         s1_sapx  <= '0;
         s2_ed    <= '0;
`ifdef APPROX_ERR_BIAS_EN
         s2_diff  <= '0;
`endif
      end else begin
         s1_vld <= accept;
         s2_vld <= s1_vld;
         if (accept) begin
            s1_exact <= {1'b0, a} + {1'b0, b};
            s1_sapx  <= s_approx;
         end
         if (s1_vld) begin
            s2_ed   <= ed_c;
`ifdef APPROX_ERR_BIAS_EN
            s2_diff <= diff;
`endif
         end
      end
   end

   // Run accumulators; the means are captured on the step into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
         mean_ed   <= '0;
`ifdef APPROX_ERR_BIAS_EN
         bias_acc  <= '0;
         mean_bias <= '0;
`endif
      end else if (clear) begin
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
         mean_ed   <= '0;
`ifdef APPROX_ERR_BIAS_EN
         bias_acc  <= '0;
         mean_bias <= '0;
`endif
      end else begin
         if (s2_vld) begin
            sum_ed    <= sum_ed + ACC_W'(s2_ed);
            err_count <= err_count + (LOG2_N+1)'(s2_ed != '0);
            if (s2_ed > max_ed) max_ed <= s2_ed;
`ifdef APPROX_ERR_BIAS_EN
            bias_acc  <= bias_acc + (ACC_W+1)'(s2_diff);
`endif
         end
         if (enter_done) begin
            mean_ed   <= (WIDTH+1)'(sum_ed >> LOG2_N);
`ifdef APPROX_ERR_BIAS_EN
            mean_bias <= (WIDTH+2)'(bias_acc >>> LOG2_N);
`endif
         end
      end
   end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with a 4-sample run (LOG2_N=2).
// Each step checks outputs against hand-computed values at the falling edge.
// Bias outputs are checked when APPROX_ERR_BIAS_EN is defined.
module tb_approx_err_monitor;

   localparam int WIDTH  = 16;
   localparam int LOG2_N = 2;
   localparam int ACC_W  = WIDTH + 1 + LOG2_N;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a, b;
   logic [WIDTH:0]         s_approx;
   logic                   busy, done;
   logic [LOG2_N:0]        err_count;
   logic [ACC_W-1:0]       sum_ed;
   logic [WIDTH:0]         max_ed, mean_ed;
`ifdef APPROX_ERR_BIAS_EN
   logic signed [ACC_W:0]  bias_acc;
   logic signed [WIDTH+1:0] mean_bias;
`endif

   int total = 0;
   int bad   = 0;
   int lat;

   approx_err_monitor #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s_approx(s_approx), .busy(busy), .done(done),
      .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed), .mean_ed(mean_ed)
`ifdef APPROX_ERR_BIAS_EN
      , .bias_acc(bias_acc), .mean_bias(mean_bias)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bias(input string tag, input longint acc, input longint mb);
`ifdef APPROX_ERR_BIAS_EN
      chk({tag, "_bias_acc"}, 64'(bias_acc), 64'(acc));
      chk({tag, "_mean_bias"}, 64'(mean_bias), 64'(mb));
`endif
   endtask

   task automatic chk_res(input string tag, input int ec, input int se, input int mx, input int mn);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_err_count"}, 64'(err_count), 64'(ec));
      chk({tag, "_sum_ed"}, 64'(sum_ed), 64'(se));
      chk({tag, "_max_ed"}, 64'(max_ed), 64'(mx));
      chk({tag, "_mean_ed"}, 64'(mean_ed), 64'(mn));
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [16:0] xs);
      int n = 0;
      a = xa; b = xb; s_approx = xs; in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk({tag, "_done_timeout"}, 64'(done), 64'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; s_approx = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_sum_ed", 64'(sum_ed), 64'd0);
      chk("rst_max_ed", 64'(max_ed), 64'd0);
      chk("rst_mean_ed", 64'(mean_ed), 64'd0);
      chk_bias("rst", 0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_ready", 64'(in_ready), 64'd0);

      // Exact adder: every approximate sum is correct.
      do_start();
      chk("exact_busy", 64'(busy), 64'd1);
      chk("exact_ready", 64'(in_ready), 64'd1);
      send(16'h1234, 16'h0F0F, 17'h02143);
      send(16'h0000, 16'h0000, 17'h00000);
      send(16'hFFFF, 16'h0001, 17'h10000);
      send(16'h8000, 16'h8000, 17'h10000);
      wait_done("exact");
      chk_res("exact", 0, 0, 0, 0);
      chk_bias("exact", 0, 0);

      // Constant error of 15; start from DONE clears done on the next edge.
      do_start();
      chk("const_done_clr", 64'(done), 64'd0);
      chk("const_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 17'h0000F);
      wait_done("const");
      chk_res("const", 4, 60, 15, 15);
      chk_bias("const", 60, 15);

      // Mixed signs: -16 and +8 alternating.
      do_start();
      for (int i = 0; i < 2; i++) begin
         send(16'h00FF, 16'h0001, 17'h000F0);
         send(16'h0010, 16'h0000, 17'h00018);
      end
      wait_done("mixed");
      chk_res("mixed", 4, 48, 16, 12);
      chk_bias("mixed", -16, -4);

      // Handshake: in_valid toggling, start ignored mid-run, done 3 cycles after last accept.
      do_start();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            chk("hs_ready_drop", 64'(in_ready), 64'd0);
            chk("hs_busy_drain", 64'(busy), 64'd1);
         end
         in_valid = (i % 2 == 0);
         start    = (i == 3);
         a = 16'h0000; b = 16'h0000; s_approx = 17'h00003;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("hs_done_latency", 64'(lat), 64'd3);
      chk_res("hs", 4, 12, 3, 3);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("hs_done_ignore_sum", 64'(sum_ed), 64'd12);
      chk("hs_done_ignore_cnt", 64'(err_count), 64'd4);

      // Extreme error distances: 0x1FFFE three times and 0x1FFFF once.
      do_start();
      for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, 17'h00000);
      send(16'h0000, 16'h0000, 17'h1FFFF);
      wait_done("max");
      chk_res("max", 4, 32'h7FFF9, 32'h1FFFF, 32'h1FFFE);
      chk_bias("max", -64'sh3FFFB, -64'shFFFF);

      // Accumulator latency, then reset mid-run discards the partial results.
      do_start();
      send(16'h0000, 16'h0000, 17'h00002);
      chk("lat_sum_e1", 64'(sum_ed), 64'd0);
      @(negedge clk);
      chk("lat_sum_e2", 64'(sum_ed), 64'd0);
      @(negedge clk);
      chk("lat_sum_e3", 64'(sum_ed), 64'd2);
      send(16'h0000, 16'h0000, 17'h00002);
      send(16'h0000, 16'h0000, 17'h00002);
      @(negedge clk);
      @(negedge clk);
      chk("mid_sum", 64'(sum_ed), 64'd6);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_sum_ed", 64'(sum_ed), 64'd0);
      chk("arst_err_count", 64'(err_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(in_ready), 64'd0);
      chk("post_rst_done", 64'(done), 64'd0);
      do_start();
      for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 17'h00001);
      wait_done("after_rst");
      chk_res("after_rst", 4, 4, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
